// File: rtl/inst_fetch_stage.sv
// Instruction fetch front end: owns the PC, issues word fetches over a valid/ready
// channel, buffers in-order responses and drives the IF_ID register toward decode.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = CW + 8;

  logic [31:0]   pc_reg;
  logic [CW-1:0] in_flight_reg;
  logic [CW-1:0] in_flight_next;
  logic [DW-1:0] drop_cnt_reg;
  logic [DW-1:0] drop_flush;

  logic [31:0]   pcq_mem [BUF_DEPTH];
  logic [AW-1:0] pcq_rd_reg;
  logic [AW-1:0] pcq_wr_reg;

  logic [31:0]   rb_data_mem [BUF_DEPTH];
  logic [31:0]   rb_pc_mem   [BUF_DEPTH];
  logic [AW-1:0] rb_rd_reg;
  logic [AW-1:0] rb_wr_reg;
  logic [CW-1:0] rb_count_reg;
  logic [CW-1:0] rb_count_next;

  logic [31:0]   inst_reg;
  logic [31:0]   inst_pc_reg;
  logic          inst_valid_reg;

  logic [CW:0]   occupancy;
  logic          issue;
  logic          resp_live;
  logic          resp_drop;
  logic          buf_empty;
  logic          pop;
  logic          bypass;
  logic          push;
  logic [31:0]   pcq_head;

  // in_flight counts only live requests; stale ones are tracked in drop_cnt
  assign occupancy      = {1'b0, in_flight_reg} + {1'b0, rb_count_reg};
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = pc_reg;
  assign issue          = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_cnt_reg != '0);
  assign resp_live = imem_resp_valid && (drop_cnt_reg == '0);
  assign pcq_head  = pcq_mem[pcq_rd_reg];
  assign buf_empty = (rb_count_reg == '0);

  assign pop    = !redirect_valid && !stall && !buf_empty;
  assign bypass = !redirect_valid && !stall && buf_empty && resp_live;
  assign push   = !redirect_valid && resp_live && !bypass;

  // Every outstanding request becomes stale on a flush, minus any answered right now
  assign drop_flush = drop_cnt_reg + DW'(in_flight_reg) - DW'(imem_resp_valid);

  always_comb begin
    in_flight_next = in_flight_reg;
    if (issue)     in_flight_next = in_flight_next + CW'(1);
    if (resp_live) in_flight_next = in_flight_next - CW'(1);
  end

  always_comb begin
    rb_count_next = rb_count_reg;
    if (push) rb_count_next = rb_count_next + CW'(1);
    if (pop)  rb_count_next = rb_count_next - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      in_flight_reg <= '0;
      drop_cnt_reg  <= drop_flush;
      pcq_rd_reg    <= '0;
      pcq_wr_reg    <= '0;
      rb_rd_reg     <= '0;
      rb_wr_reg     <= '0;
      rb_count_reg  <= '0;
      pc_reg        <= rst ? RESET_PC : (redirect_pc & 32'hFFFF_FFFC);
    end else begin
      in_flight_reg <= in_flight_next;
      rb_count_reg  <= rb_count_next;
      if (resp_drop) drop_cnt_reg <= drop_cnt_reg - DW'(1);
      if (issue) begin
        pc_reg     <= pc_reg + 32'd4;
        pcq_wr_reg <= pcq_wr_reg + AW'(1);
      end
      if (resp_live) pcq_rd_reg <= pcq_rd_reg + AW'(1);
      if (push)      rb_wr_reg  <= rb_wr_reg + AW'(1);
      if (pop)       rb_rd_reg  <= rb_rd_reg + AW'(1);
    end
  end

  // Storage needs no reset: validity is carried entirely by the pointers and counts
  always_ff @(posedge clk) begin
    if (issue) pcq_mem[pcq_wr_reg] <= pc_reg;
    if (push && !rst) begin
      rb_data_mem[rb_wr_reg] <= imem_resp_data;
      rb_pc_mem[rb_wr_reg]   <= pcq_head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_reg       <= NOP_INST;
      inst_pc_reg    <= 32'h0000_0000;
      inst_valid_reg <= 1'b0;
    end else if (redirect_valid) begin
      inst_reg       <= NOP_INST;
      inst_valid_reg <= 1'b0;
    end else if (!stall) begin
      if (!buf_empty) begin
        inst_reg       <= rb_data_mem[rb_rd_reg];
        inst_pc_reg    <= rb_pc_mem[rb_rd_reg];
        inst_valid_reg <= 1'b1;
      end else if (resp_live) begin
        inst_reg       <= imem_resp_data;
        inst_pc_reg    <= pcq_head;
        inst_valid_reg <= 1'b1;
      end else begin
        inst_reg       <= NOP_INST;
        inst_valid_reg <= 1'b0;
      end
    end
  end

  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_valid = inst_valid_reg;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: random memory latency/readiness, stalls, redirects and resets,
// checked against a stream-level model of the expected instruction sequence.
module tb_inst_fetch_stage;

  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC   = 32'hFFFF_FFF8;
  localparam logic [31:0] DMASK     = 32'hA5A5_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  inst_fetch_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  // Second instance starting near the top of the address space, always-ready memory, latency 1
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_inst_valid;
  logic [31:0] w_log [$];

  inst_fetch_stage #(.RESET_PC(WRAP_PC), .BUF_DEPTH(BUF_DEPTH), .NOP_INST(NOP)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(1'b1),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst(w_inst), .inst_pc(w_inst_pc), .inst_valid(w_inst_valid)
  );

  always @(posedge clk) begin
    w_resp_valid <= !rst && w_req_valid;
    w_resp_data  <= w_req_addr ^ DMASK;
    if (!rst && w_req_valid && w_log.size() < 3) w_log.push_back(w_req_addr);
  end

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mq [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          epoch, avail, cyc, lat_min, lat_max, ready_pct;
  bit          armed;
  logic [31:0] exp_next, exp_req, exp_inst, exp_pc;
  logic        exp_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock cycle: check the last edge, apply stimulus, play memory, advance the model
  task automatic step(input logic r, input logic rd, input logic [31:0] rp, input logic st);
    int   live_out;
    logic live_resp;
    logic exp_rv;
    if (armed) begin
      if (inst_valid) $display("cycle %0d inst_pc=%08h inst=%08h", cyc, inst_pc, inst);
      check("inst", inst, exp_inst);
      check("inst_pc", inst_pc, exp_pc);
      check("inst_valid", 32'(inst_valid), 32'(exp_valid));
    end
    rst            = r;
    redirect_valid = rd;
    redirect_pc    = rp;
    stall          = st;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    live_out = 0;
    foreach (mq[i]) if (mq[i].epoch == epoch) live_out++;
    live_resp = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mq[0].addr ^ DMASK;
      live_resp       = (mq[0].epoch == epoch);
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #1;
    exp_rv = !r && !rd && (live_out + avail < BUF_DEPTH);
    if (armed) begin
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      check("occupancy", 32'(live_out + avail <= BUF_DEPTH), 32'd1);
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req);
      mq.push_back('{imem_req_addr, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
      exp_req = exp_req + 32'd4;
    end
    if (r) begin
      exp_inst = NOP; exp_pc = 32'h0; exp_valid = 1'b0; avail = 0;
      exp_next = RESET_PC; exp_req = RESET_PC; epoch++;
    end else if (rd) begin
      exp_inst = NOP; exp_valid = 1'b0; avail = 0;
      exp_next = rp & 32'hFFFF_FFFC; exp_req = exp_next; epoch++;
    end else begin
      if (live_resp) avail++;
      if (!st) begin
        if (avail > 0) begin
          exp_inst = exp_next ^ DMASK; exp_pc = exp_next; exp_valid = 1'b1;
          exp_next = exp_next + 32'd4; avail--;
        end else begin
          exp_inst = NOP; exp_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (r) armed = 1'b1;
  endtask

  initial begin
    logic [31:0] wexp;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    epoch = 0; avail = 0; cyc = 0; armed = 1'b0;
    ready_pct = 100; lat_min = 1; lat_max = 1;
    exp_next = RESET_PC; exp_req = RESET_PC; exp_inst = NOP; exp_pc = 32'h0; exp_valid = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (5)  step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);
    lat_min = 2; lat_max = 2;
    repeat (6)  step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    repeat (8)  step(1'b0, 1'b0, 32'h0, 1'b0);
    lat_min = 3; lat_max = 3;
    repeat (5)  step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b0);
    lat_min = 1; lat_max = 4; ready_pct = 70;
    repeat (1500) begin
      step($urandom_range(99) < 1, $urandom_range(99) < 3, $urandom, $urandom_range(99) < 20);
    end
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap_count", 32'(w_log.size()), 32'd3);
    wexp = WRAP_PC;
    for (int i = 0; i < 3; i++) begin
      check("wrap_addr", (i < w_log.size()) ? w_log[i] : 32'hDEAD_BEEF, wexp);
      wexp = wexp + 32'd4;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
